// File: rtl/vm_order_entry.sv
// Order-entry front end for vending_machine: coin credit, two-key selection, one command per entry.
// Optional entry timeout: define VM_ENTRY_TIMEOUT_EN. Product type port is sel_type (type is a keyword).
module vm_order_entry #(
    parameter int unsigned RESP_WAIT = 2,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       btn_buy,
    input  logic       btn_refill,
    input  logic       btn_cancel,
    input  logic       status,
    output logic [1:0] mode,
    output logic [3:0] in_money,
    output logic [3:0] sel_type,
    output logic [3:0] number,
    output logic       cmd_valid,
    output logic       busy,
    output logic [3:0] credit,
    output logic       coin_reject,
    output logic       result_valid,
    output logic       result_ok
);

    typedef enum logic [2:0] {StIdle, StGotType, StReady, StIssue, StWait} state_e;

    localparam logic [1:0] ModeBuy    = 2'd0;
    localparam logic [1:0] ModeRefill = 2'd1;
    localparam logic [1:0] ModeRefund = 2'd2;

    state_e     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [3:0] in_money_q, in_money_d;
    logic [3:0] type_q, type_d;
    logic [3:0] number_q, number_d;
    logic [3:0] credit_q, credit_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       coin_reject_q, coin_reject_d;
    logic       result_valid_q, result_valid_d;
    logic       result_ok_q, result_ok_d;

    logic       entry;
    logic [4:0] coin_amt;
    logic [4:0] coin_sum;
    logic [3:0] credit_now;
    logic       to_expired;

    assign entry = (state_q == StIdle) || (state_q == StGotType) || (state_q == StReady);

    always_comb begin
        coin_amt = 5'd1;
        unique case (coin_value)
            2'b00:   coin_amt = 5'd1;
            2'b01:   coin_amt = 5'd2;
            2'b10:   coin_amt = 5'd5;
            default: coin_amt = 5'd10;
        endcase
    end

    assign coin_sum = {1'b0, credit_q} + coin_amt;

`ifdef VM_ENTRY_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT + 1);

    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           any_event;
    logic           to_running;

    assign any_event  = coin_valid | key_valid | btn_buy | btn_refill | btn_cancel;
    assign to_running = (state_q == StGotType) || (state_q == StReady);
    assign to_expired = to_running && !any_event && (to_cnt_q == ToW'(TIMEOUT - 1));

    always_comb begin
        to_cnt_d = '0;
        if (to_running && !any_event && !to_expired) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_expired = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        in_money_d     = in_money_q;
        type_d         = type_q;
        number_d       = number_q;
        wait_cnt_d     = wait_cnt_q;
        coin_reject_d  = 1'b0;
        result_valid_d = 1'b0;
        result_ok_d    = result_ok_q;
        credit_now     = credit_q;

        // Coin lands before any command decision so the command sees the new credit.
        if (coin_valid) begin
            if (entry) begin
                credit_now    = coin_sum[4] ? 4'hF : coin_sum[3:0];
                coin_reject_d = coin_sum[4];
            end else begin
                coin_reject_d = 1'b1;
            end
        end
        credit_d = credit_now;

        case (state_q)
            StIdle, StGotType, StReady: begin
                if (btn_cancel) begin
                    type_d   = 4'd0;
                    number_d = 4'd0;
                    if (credit_now != 4'd0) begin
                        state_d    = StIssue;
                        mode_d     = ModeRefund;
                        in_money_d = credit_now;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (btn_buy || btn_refill) begin
                    if (state_q == StReady) begin
                        state_d    = StIssue;
                        mode_d     = btn_buy ? ModeBuy : ModeRefill;
                        in_money_d = btn_buy ? credit_now : 4'd0;
                    end
                end else if (key_valid) begin
                    if (state_q == StGotType) begin
                        number_d = key_code;
                        state_d  = StReady;
                    end else begin
                        type_d  = key_code;
                        state_d = StGotType;
                    end
                end else if (to_expired) begin
                    type_d   = 4'd0;
                    number_d = 4'd0;
                    state_d  = StIdle;
                end
            end
            StIssue: begin
                state_d    = StWait;
                wait_cnt_d = 4'd0;
            end
            StWait: begin
                if (wait_cnt_q == 4'(RESP_WAIT)) begin
                    state_d        = StIdle;
                    result_valid_d = 1'b1;
                    result_ok_d    = status;
                    type_d         = 4'd0;
                    number_d       = 4'd0;
                    if ((mode_q == ModeRefund) || ((mode_q == ModeBuy) && status)) begin
                        credit_d = 4'd0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            mode_q         <= 2'd0;
            in_money_q     <= 4'd0;
            type_q         <= 4'd0;
            number_q       <= 4'd0;
            credit_q       <= 4'd0;
            wait_cnt_q     <= 4'd0;
            coin_reject_q  <= 1'b0;
            result_valid_q <= 1'b0;
            result_ok_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            in_money_q     <= in_money_d;
            type_q         <= type_d;
            number_q       <= number_d;
            credit_q       <= credit_d;
            wait_cnt_q     <= wait_cnt_d;
            coin_reject_q  <= coin_reject_d;
            result_valid_q <= result_valid_d;
            result_ok_q    <= result_ok_d;
        end
    end

    assign mode         = mode_q;
    assign in_money     = in_money_q;
    assign sel_type     = type_q;
    assign number       = number_q;
    assign credit       = credit_q;
    assign cmd_valid    = (state_q == StIssue);
    assign busy         = (state_q == StIssue) || (state_q == StWait);
    assign coin_reject  = coin_reject_q;
    assign result_valid = result_valid_q;
    assign result_ok    = result_ok_q;

endmodule

// File: tb/tb_vm_order_entry.sv
// Directed self-checking bench for vm_order_entry (RESP_WAIT=2, TIMEOUT=8).
module tb_vm_order_entry;

    localparam int unsigned RW = 2;
    localparam int unsigned TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid, key_valid, btn_buy, btn_refill, btn_cancel, status;
    logic [1:0] coin_value;
    logic [3:0] key_code;
    logic [1:0] mode;
    logic [3:0] in_money, sel_type, number, credit;
    logic       cmd_valid, busy, coin_reject, result_valid, result_ok;

    int checks = 0;
    int errors = 0;

    vm_order_entry #(.RESP_WAIT(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_value(coin_value),
        .key_valid(key_valid), .key_code(key_code),
        .btn_buy(btn_buy), .btn_refill(btn_refill), .btn_cancel(btn_cancel),
        .status(status),
        .mode(mode), .in_money(in_money), .sel_type(sel_type), .number(number),
        .cmd_valid(cmd_valid), .busy(busy), .credit(credit), .coin_reject(coin_reject),
        .result_valid(result_valid), .result_ok(result_ok)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic press(input logic c, input logic b, input logic r);
        btn_cancel = c;
        btn_buy    = b;
        btn_refill = r;
        tick();
        btn_cancel = 1'b0;
        btn_buy    = 1'b0;
        btn_refill = 1'b0;
    endtask

    // Called just after the button edge; result must appear RW+2 edges after that edge.
    task automatic run_cmd(input logic [1:0] m, input logic [3:0] im, input logic [3:0] t,
                           input logic [3:0] n, input logic ok);
        check_eq("cmd_valid", 16'(cmd_valid), 16'd1);
        check_eq("busy_issue", 16'(busy), 16'd1);
        check_eq("mode", 16'(mode), 16'(m));
        check_eq("in_money", 16'(in_money), 16'(im));
        check_eq("type", 16'(sel_type), 16'(t));
        check_eq("number", 16'(number), 16'(n));
        for (int i = 1; i <= int'(RW) + 1; i++) begin
            tick();
            check_eq("rv_early", 16'(result_valid), 16'd0);
            if (i == 1) check_eq("cmd_valid_1cyc", 16'(cmd_valid), 16'd0);
        end
        check_eq("mode_stable", 16'(mode), 16'(m));
        check_eq("in_money_stable", 16'(in_money), 16'(im));
        check_eq("number_stable", 16'(number), 16'(n));
        tick();
        check_eq("result_valid", 16'(result_valid), 16'd1);
        check_eq("result_ok", 16'(result_ok), 16'(ok));
        check_eq("busy_done", 16'(busy), 16'd0);
        check_eq("type_cleared", 16'(sel_type), 16'd0);
        check_eq("number_cleared", 16'(number), 16'd0);
        tick();
        check_eq("result_valid_pulse", 16'(result_valid), 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        coin_valid = 1'b0; coin_value = 2'd0; key_valid = 1'b0; key_code = 4'd0;
        btn_buy = 1'b0; btn_refill = 1'b0; btn_cancel = 1'b0; status = 1'b0;
        #12;
        check_eq("rst_credit", 16'(credit), 16'd0);
        check_eq("rst_mode", 16'(mode), 16'd0);
        check_eq("rst_busy", 16'(busy), 16'd0);
        check_eq("rst_cmd_valid", 16'(cmd_valid), 16'd0);
        check_eq("rst_type", 16'(sel_type), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: 10 + 5 = 15 exactly, then +1 clips.
        coin(2'b11); check_eq("c10", 16'(credit), 16'd10); check_eq("rej0", 16'(coin_reject), 16'd0);
        coin(2'b10); check_eq("c15", 16'(credit), 16'd15); check_eq("rej1", 16'(coin_reject), 16'd0);
        coin(2'b00); check_eq("c_sat", 16'(credit), 16'd15); check_eq("rej_clip", 16'(coin_reject), 16'd1);
        tick(); check_eq("rej_pulse", 16'(coin_reject), 16'd0);

        // Refund from IDLE always clears credit, even on a failed status.
        press(1'b1, 1'b0, 1'b0);
        run_cmd(2'd2, 4'd15, 4'd0, 4'd0, 1'b0);
        check_eq("refund_clear", 16'(credit), 16'd0);

        // Successful purchase: 5+2+2 = 9.
        coin(2'b10); coin(2'b01); coin(2'b01);
        check_eq("c9", 16'(credit), 16'd9);
        key(4'd0); key(4'd1);
        status = 1'b1;
        press(1'b0, 1'b1, 1'b0);
        run_cmd(2'd0, 4'd9, 4'd0, 4'd1, 1'b1);
        check_eq("buy_ok_clear", 16'(credit), 16'd0);

        // Failed purchase keeps credit 13.
        coin(2'b11); coin(2'b01); coin(2'b00);
        check_eq("c13", 16'(credit), 16'd13);
        key(4'd3); key(4'd2);
        status = 1'b0;
        press(1'b0, 1'b1, 1'b0);
        run_cmd(2'd0, 4'd13, 4'd3, 4'd2, 1'b0);
        check_eq("buy_fail_keep", 16'(credit), 16'd13);

        // Restock leaves credit untouched.
        key(4'd0); key(4'd15);
        status = 1'b1;
        press(1'b0, 1'b0, 1'b1);
        run_cmd(2'd1, 4'd0, 4'd0, 4'd15, 1'b1);
        check_eq("refill_keep", 16'(credit), 16'd13);

        press(1'b1, 1'b0, 1'b0);
        run_cmd(2'd2, 4'd13, 4'd0, 4'd0, 1'b1);

        // Cancel beats buy in the same cycle; coin during WAIT is refused.
        coin(2'b01); key(4'd5); key(4'd6);
        press(1'b1, 1'b1, 1'b0);
        check_eq("prio_mode", 16'(mode), 16'd2);
        check_eq("prio_money", 16'(in_money), 16'd2);
        check_eq("prio_type", 16'(sel_type), 16'd0);
        tick();
        coin(2'b10);
        check_eq("wait_coin_rej", 16'(coin_reject), 16'd1);
        check_eq("wait_coin_credit", 16'(credit), 16'd2);
        tick(); check_eq("prio_rv_early", 16'(result_valid), 16'd0);
        tick(); check_eq("prio_rv", 16'(result_valid), 16'd1);
        check_eq("prio_credit", 16'(credit), 16'd0);

        // Coin and buy together: command carries the new credit.
        key(4'd1); key(4'd2);
        coin_valid = 1'b1; coin_value = 2'b10;
        press(1'b0, 1'b1, 1'b0);
        coin_valid = 1'b0;
        run_cmd(2'd0, 4'd5, 4'd1, 4'd2, 1'b1);
        check_eq("coinbuy_clear", 16'(credit), 16'd0);

        // Cancel with no credit only clears selection.
        key(4'd7);
        check_eq("type7", 16'(sel_type), 16'd7);
        press(1'b1, 1'b0, 1'b0);
        check_eq("cancel0_cmd", 16'(cmd_valid), 16'd0);
        check_eq("cancel0_busy", 16'(busy), 16'd0);
        check_eq("cancel0_type", 16'(sel_type), 16'd0);

        key(4'd4);
`ifdef VM_ENTRY_TIMEOUT_EN
        for (int i = 0; i < int'(TO) - 1; i++) tick();
        check_eq("to_before", 16'(sel_type), 16'd4);
        tick();
        check_eq("to_after", 16'(sel_type), 16'd0);
`else
        for (int i = 0; i < 20; i++) tick();
        check_eq("no_timeout", 16'(sel_type), 16'd4);
        press(1'b1, 1'b0, 1'b0);
`endif

        // Asynchronous reset in the middle of WAIT.
        coin(2'b10); key(4'd1); key(4'd1);
        press(1'b0, 1'b1, 1'b0);
        tick();
        check_eq("pre_rst_busy", 16'(busy), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 16'(busy), 16'd0);
        check_eq("arst_credit", 16'(credit), 16'd0);
        check_eq("arst_mode", 16'(mode), 16'd0);
        check_eq("arst_money", 16'(in_money), 16'd0);
        check_eq("arst_type", 16'(sel_type), 16'd0);
        check_eq("arst_number", 16'(number), 16'd0);
        check_eq("arst_rv", 16'(result_valid), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_cmd", 16'(cmd_valid), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
